// File: rtl/alpha_blend_pkg.sv
// Shared constants for the N-channel alpha blender: alpha source modes and
// the full-scale alpha value derived from the alpha width.
package alpha_blend_pkg;

  localparam logic [1:0] MODE_PIXEL  = 2'd0;
  localparam logic [1:0] MODE_GLOBAL = 2'd1;
  localparam logic [1:0] MODE_FADE   = 2'd2;
  localparam logic [1:0] MODE_BYPASS = 2'd3;

  // Full-scale alpha (fully foreground) for an alpha of the given width.
  function automatic logic [31:0] amax_of(input int unsigned aw);
    return (32'd1 << aw) - 32'd1;
  endfunction

endpackage

// File: rtl/alpha_blend_nch_channel.sv
// One colour channel of the blender: four registered stages computing
// round((F*a + B*(AMAX-a)) / AMAX), saturated to the channel width.
module blend_channel
  import alpha_blend_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          sys_clk,
  input  logic          rst,
  input  logic [DW-1:0] f,
  input  logic [DW-1:0] b,
  input  logic [AW-1:0] a,
  output logic [DW-1:0] y
);

  localparam int PW = DW + AW;
  localparam int SW = PW + 1;
  localparam int RW = SW + 1;
  localparam logic [31:0]   AMAX_32 = amax_of(AW);
  localparam logic [AW-1:0] AMAX    = AMAX_32[AW-1:0];
  localparam logic [SW-1:0] HALF    = SW'(1) << (AW - 1);
  localparam logic [DW-1:0] DMAX    = {DW{1'b1}};

  logic [DW-1:0] f1, b1;
  logic [AW-1:0] a1;
  logic [PW-1:0] pf2, pb2;
  logic [SW-1:0] t3;
  logic [RW-1:0] r4;

  // Divide by AMAX as (t + t/2^AW) / 2^AW; t already carries the half-LSB bias.
  assign r4 = ({1'b0, t3} + {1'b0, (t3 >> AW)}) >> AW;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      f1  <= '0;
      b1  <= '0;
      a1  <= '0;
      pf2 <= '0;
      pb2 <= '0;
      t3  <= '0;
      y   <= '0;
    end else begin
      f1  <= f;
      b1  <= b;
      a1  <= a;
      pf2 <= PW'(f1) * PW'(a1);
      pb2 <= PW'(b1) * PW'(AMAX - a1);
      t3  <= SW'(pf2) + SW'(pb2) + HALF;
      y   <= (r4 > RW'(DMAX)) ? DMAX : r4[DW-1:0];
    end
  end

endmodule

// File: rtl/alpha_blend_nch.sv
// N-channel alpha blender. Mode and global settings are latched on the rising
// edge of v_sync so a frame is never torn; output lags input by 4 clocks.
module alpha_blend_nch
  import alpha_blend_pkg::*;
#(
  parameter int CH = 3,
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             i_h_sync,
  input  logic             i_v_sync,
  input  logic             i_de,
  input  logic [CH*DW-1:0] i_back_ground,
  input  logic [CH*DW-1:0] i_front_ground,
  input  logic [AW-1:0]    i_alpha,
  input  logic [1:0]       i_mode,
  input  logic [AW-1:0]    i_global_alpha,
  input  logic [AW-1:0]    i_fade_step,
  input  logic             i_fade_dir,
  output logic             o_h_sync,
  output logic             o_v_sync,
  output logic             o_de,
  output logic [CH*DW-1:0] o_data,
  output logic             o_fade_done
);

  localparam logic [31:0]   AMAX_32 = amax_of(AW);
  localparam logic [AW-1:0] AMAX    = AMAX_32[AW-1:0];

  // No handshake: one pixel is accepted and one produced on every clock.
  logic          vs_prev, vs_rise;
  logic [1:0]    mode_q;
  logic [AW-1:0] galpha_q, fade_a, fade_up, fade_dn, fade_end, alpha_sel;
  logic          dir_q;
  logic [AW:0]   up_sum;
  logic [3:0]    hs_sr, vs_sr, de_sr;

  assign vs_rise = i_v_sync & ~vs_prev;

  always_comb begin
    up_sum   = {1'b0, fade_a} + {1'b0, i_fade_step};
    fade_up  = (up_sum > {1'b0, AMAX}) ? AMAX : up_sum[AW-1:0];
    fade_dn  = (fade_a > i_fade_step) ? (fade_a - i_fade_step) : '0;
    fade_end = dir_q ? '0 : AMAX;
  end

  always_comb begin
    alpha_sel = i_alpha;
    case (mode_q)
      MODE_PIXEL:  alpha_sel = i_alpha;
      MODE_GLOBAL: alpha_sel = galpha_q;
      MODE_FADE:   alpha_sel = fade_a;
      MODE_BYPASS: alpha_sel = AMAX;
      default:     alpha_sel = i_alpha;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      vs_prev     <= 1'b0;
      mode_q      <= MODE_PIXEL;
      galpha_q    <= '0;
      dir_q       <= 1'b0;
      fade_a      <= '0;
      o_fade_done <= 1'b0;
    end else begin
      vs_prev     <= i_v_sync;
      o_fade_done <= (mode_q == MODE_FADE) && (fade_a == fade_end);
      if (vs_rise) begin
        mode_q   <= i_mode;
        galpha_q <= i_global_alpha;
        dir_q    <= i_fade_dir;
        // Entering fade starts at the far end; staying in fade steps with the new direction.
        if (i_mode == MODE_FADE && mode_q != MODE_FADE)
          fade_a <= i_fade_dir ? AMAX : '0;
        else if (i_mode == MODE_FADE && mode_q == MODE_FADE)
          fade_a <= i_fade_dir ? fade_dn : fade_up;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      hs_sr <= '0;
      vs_sr <= '0;
      de_sr <= '0;
    end else begin
      hs_sr <= {hs_sr[2:0], i_h_sync};
      vs_sr <= {vs_sr[2:0], i_v_sync};
      de_sr <= {de_sr[2:0], i_de};
    end
  end

  assign o_h_sync = hs_sr[3];
  assign o_v_sync = vs_sr[3];
  assign o_de     = de_sr[3];

  for (genvar k = 0; k < CH; k++) begin : g_ch
    blend_channel #(.DW(DW), .AW(AW)) u_ch (
      .sys_clk (sys_clk),
      .rst     (rst),
      .f       (i_front_ground[k*DW +: DW]),
      .b       (i_back_ground[k*DW +: DW]),
      .a       (alpha_sel),
      .y       (o_data[k*DW +: DW])
    );
  end

endmodule

// File: tb/tb_alpha_blend_nch.sv
// Bench for alpha_blend_nch: randomized pixels and frames against a
// behavioural model of the blend and frame-latched settings.
module tb_alpha_blend_nch;

  localparam int CH   = 3;
  localparam int DW   = 8;
  localparam int AW   = 8;
  localparam int AMAX = 255;
  localparam int PW   = CH * DW;
  localparam int W    = PW + 3;

  logic          sys_clk, rst;
  logic          i_h_sync, i_v_sync, i_de, i_fade_dir;
  logic [PW-1:0] i_back_ground, i_front_ground;
  logic [AW-1:0] i_alpha, i_global_alpha, i_fade_step;
  logic [1:0]    i_mode;
  logic          o_h_sync, o_v_sync, o_de, o_fade_done;
  logic [PW-1:0] o_data;

  alpha_blend_nch #(.CH(CH), .DW(DW), .AW(AW)) dut (
    .sys_clk        (sys_clk),
    .rst            (rst),
    .i_h_sync       (i_h_sync),
    .i_v_sync       (i_v_sync),
    .i_de           (i_de),
    .i_back_ground  (i_back_ground),
    .i_front_ground (i_front_ground),
    .i_alpha        (i_alpha),
    .i_mode         (i_mode),
    .i_global_alpha (i_global_alpha),
    .i_fade_step    (i_fade_step),
    .i_fade_dir     (i_fade_dir),
    .o_h_sync       (o_h_sync),
    .o_v_sync       (o_v_sync),
    .o_de           (o_de),
    .o_data         (o_data),
    .o_fade_done    (o_fade_done)
  );

  // Clock / reset
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  int m_mode = 0, m_galpha = 0, m_dir = 0, m_fade = 0;
  bit m_vs_prev = 1'b0;
  bit exp_done  = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [PW-1:0] blend_ref(input logic [PW-1:0] f, input logic [PW-1:0] b,
                                              input int a);
    logic [PW-1:0] res;
    res = '0;
    for (int k = 0; k < CH; k++) begin
      int fk, bk, s, r;
      fk = int'(f[k*DW +: DW]);
      bk = int'(b[k*DW +: DW]);
      s  = fk * a + bk * (AMAX - a);
      r  = (2 * s + AMAX) / (2 * AMAX);
      if (r > 255) r = 255;
      res[k*DW +: DW] = r[DW-1:0];
    end
    return res;
  endfunction

  // Behavioural model: expected output per captured pixel, frame-latched settings.
  always @(posedge sys_clk) begin : model
    int a;
    if (rst) begin
      m_mode = 0; m_galpha = 0; m_dir = 0; m_fade = 0;
      m_vs_prev = 1'b0;
      exp_done  = 1'b0;
      exp_q.delete();
    end else begin
      exp_done = (m_mode == 2) && (m_fade == (m_dir != 0 ? 0 : AMAX));
      case (m_mode)
        0:       a = int'(i_alpha);
        1:       a = m_galpha;
        2:       a = m_fade;
        default: a = AMAX;
      endcase
      exp_q.push_back({i_h_sync, i_v_sync, i_de, blend_ref(i_front_ground, i_back_ground, a)});
      if (i_v_sync && !m_vs_prev) begin
        if (i_mode == 2 && m_mode != 2)
          m_fade = i_fade_dir ? AMAX : 0;
        else if (i_mode == 2 && m_mode == 2) begin
          if (i_fade_dir) m_fade = (m_fade - int'(i_fade_step) < 0) ? 0 : m_fade - int'(i_fade_step);
          else m_fade = (m_fade + int'(i_fade_step) > AMAX) ? AMAX : m_fade + int'(i_fade_step);
        end
        m_mode   = int'(i_mode);
        m_galpha = int'(i_global_alpha);
        m_dir    = int'(i_fade_dir);
      end
      m_vs_prev = i_v_sync;
    end
  end

  // Scoreboard compare on the falling edge.
  always @(negedge sys_clk) begin : compare
    logic [W-1:0] e;
    if (!rst) begin
      chk("fade_done", o_fade_done, exp_done);
      if (exp_q.size() == 4) begin
        e = exp_q.pop_front();
        chk("data",   o_data,   e[PW-1:0]);
        chk("de",     o_de,     e[PW]);
        chk("v_sync", o_v_sync, e[PW+1]);
        chk("h_sync", o_h_sync, e[PW+2]);
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic rand_px(input int n);
    for (int i = 0; i < n; i++) begin
      i_front_ground = PW'($urandom);
      i_back_ground  = PW'($urandom);
      case ($urandom_range(0, 3))
        0:       i_alpha = '0;
        1:       i_alpha = '1;
        default: i_alpha = AW'($urandom);
      endcase
      i_de     = ($urandom_range(0, 4) != 0);
      i_h_sync = (i % 8 == 0);
      tick();
    end
    i_h_sync = 1'b0;
  endtask

  task automatic frame(input int mode, input int galpha, input int step, input int dir);
    i_mode         = mode[1:0];
    i_global_alpha = galpha[AW-1:0];
    i_fade_step    = step[AW-1:0];
    i_fade_dir     = dir[0];
    i_de           = 1'b0;
    i_v_sync       = 1'b1;
    tick();
    tick();
    i_v_sync = 1'b0;
  endtask

  task automatic chk_zero_outputs();
    chk("rst_data",   o_data,      '0);
    chk("rst_de",     o_de,        1'b0);
    chk("rst_hs",     o_h_sync,    1'b0);
    chk("rst_vs",     o_v_sync,    1'b0);
    chk("rst_done",   o_fade_done, 1'b0);
  endtask

  task automatic single_px(input logic [PW-1:0] f, input logic [PW-1:0] b, input logic [AW-1:0] a);
    i_front_ground = f;
    i_back_ground  = b;
    i_alpha        = a;
    i_de           = 1'b1;
    tick();
    i_de = 1'b0;
    i_front_ground = PW'($urandom);
    i_back_ground  = PW'($urandom);
    repeat (3) tick();
  endtask

  initial begin
    rst = 1'b1;
    i_h_sync = 0; i_v_sync = 0; i_de = 0; i_fade_dir = 0;
    i_back_ground = '0; i_front_ground = '0; i_alpha = '0;
    i_mode = '0; i_global_alpha = '0; i_fade_step = '0;
    repeat (3) tick();
    chk_zero_outputs();
    rst = 1'b0;

    // Per-pixel blending, including a=0 and a=AMAX extremes.
    frame(0, 0, 0, 0);
    rand_px(24);
    single_px({3{8'd200}}, {3{8'd100}}, 8'd128);
    chk("blend_150", o_data, {3{8'd150}});
    chk("de_150", o_de, 1'b1);
    single_px(24'hA1B2C3, 24'h102030, 8'd0);
    chk("alpha0_is_b", o_data, 24'h102030);
    single_px(24'hA1B2C3, 24'h102030, 8'd255);
    chk("alpha255_is_f", o_data, 24'hA1B2C3);

    // Mode request changes mid-line; takes effect only at the next frame.
    i_mode = 2'd1;
    i_global_alpha = '0;
    rand_px(12);
    chk("mode_not_yet", 64'(m_mode), 64'd0);
    frame(1, 0, 0, 0);
    chk("mode_global", 64'(m_mode), 64'd1);
    rand_px(12);
    single_px(24'h112233, 24'h445566, 8'd200);
    chk("global0_is_b", o_data, 24'h445566);

    // Fade in, step 100: 0, 100, 200, 255.
    frame(2, 0, 100, 0);
    chk("fade_in_0", 64'(m_fade), 64'd0);
    rand_px(6);
    frame(2, 0, 100, 0);
    chk("fade_in_100", 64'(m_fade), 64'd100);
    single_px({3{8'd255}}, '0, 8'd0);
    chk("fade_px_100", o_data, {3{8'd100}});
    frame(2, 0, 100, 0);
    chk("fade_in_200", 64'(m_fade), 64'd200);
    rand_px(6);
    frame(2, 0, 100, 0);
    chk("fade_in_255", 64'(m_fade), 64'd255);
    rand_px(6);
    chk("fade_in_done", o_fade_done, 1'b1);

    // Fade out entered with step 0 holds at AMAX, then a full step reaches 0.
    frame(0, 0, 0, 0);
    rand_px(4);
    frame(2, 0, 0, 1);
    chk("fade_out_entry", 64'(m_fade), 64'd255);
    rand_px(6);
    frame(2, 0, 0, 1);
    chk("fade_out_hold", 64'(m_fade), 64'd255);
    single_px(24'h5A6B7C, 24'h010203, 8'd9);
    chk("fade_hold_is_f", o_data, 24'h5A6B7C);
    chk("fade_hold_not_done", o_fade_done, 1'b0);
    frame(2, 0, 255, 1);
    chk("fade_out_0", 64'(m_fade), 64'd0);
    rand_px(6);
    chk("fade_out_done", o_fade_done, 1'b1);

    // Random frames across all modes, steps and direction changes.
    repeat (16) begin
      frame($urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255),
            $urandom_range(0, 1));
      rand_px($urandom_range(4, 20));
    end
    repeat (6) begin
      frame(2, 0, $urandom_range(0, 120), $urandom_range(0, 1));
      rand_px($urandom_range(4, 10));
    end

    // Reset mid-frame while fading.
    frame(2, 0, 50, 0);
    frame(2, 0, 50, 0);
    rand_px(5);
    rst = 1'b1;
    #1;
    chk_zero_outputs();
    tick();
    tick();
    chk("rst_model_mode", 64'(m_mode), 64'd0);
    rst = 1'b0;
    i_mode = 2'd2;
    rand_px(8);
    frame(0, 0, 0, 0);
    rand_px(16);

    i_de = 1'b0;
    repeat (6) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
